generate_clock_enable: RTL and testbench



---
 rtl/generate_clock_enable_pkg.sv | 18 +
 rtl/generate_clock_enable_if.sv | 11 +
 rtl/generate_clock_enable_mod_counter.sv | 34 +++
 rtl/generate_clock_enable.sv | 43 ++++
 tb/tb_generate_clock_enable.sv | 108 ++++++++++
 5 files changed

// File: rtl/generate_clock_enable_pkg.sv
// Shared constants and helpers for the clock-enable generator.
// Consumed by generate_clock_enable and mod_counter via import clk_enable_pkg::*.
package clk_enable_pkg;

    localparam int SYS_CLK_FREQ_HZ = 50_000_000;
    localparam int GAME_TICK_MS    = 660;

    // Cycles in a period of `ms` milliseconds; divide first so 32-bit math never overflows.
    function automatic int ms_to_cycles(input int freq_hz, input int ms);
        return (freq_hz / 1000) * ms;
    endfunction

    // Counter width for a modulus; a modulus of 1 still gets one (constant) bit.
    function automatic int count_width(input int modulus);
        return (modulus <= 1) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/generate_clock_enable_if.sv
// Strobe bundle from the clock-enable generator to its slow consumers.
// phase carries the current counter value, zero-extended, for consumers that need sub-tick position.
interface generate_clock_enable_if;

    logic        six_hundred_sixty_ms;
    logic [31:0] phase;

    modport master (output six_hundred_sixty_ms, output phase);
    modport slave  (input  six_hundred_sixty_ms, input  phase);

endinterface

// File: rtl/generate_clock_enable_mod_counter.sv
// Free-running modulo-MODULUS counter with a terminal-count flag.
// Counts 0..MODULUS-1 and wraps explicitly, so power-of-two and odd moduli behave alike.
module mod_counter
    import clk_enable_pkg::*;
#(
    parameter int MODULUS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic [count_width(MODULUS)-1:0]    count,
    output logic                               terminal
);

    localparam int            CW   = count_width(MODULUS);
    localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // With MODULUS 1 the count is pinned at 0, so the flag is simply "out of reset".
    if (MODULUS == 1) begin : g_unit
        assign terminal = reset;
    end else begin : g_multi
        assign terminal = (count == LAST);
    end

endmodule

// File: rtl/generate_clock_enable.sv
// Single-cycle clock-enable strobe every PERIOD_CYCLES clocks (660 ms at 50 MHz by default).
// Define GEN_CLK_ENABLE_SIM_SHORT_EN to use SIM_PERIOD_CYCLES instead for short simulations.
module generate_clock_enable
    import clk_enable_pkg::*;
#(
    parameter int CLK_FREQ_HZ       = SYS_CLK_FREQ_HZ,
    parameter int PERIOD_MS         = GAME_TICK_MS,
    parameter int PERIOD_CYCLES     = ms_to_cycles(CLK_FREQ_HZ, PERIOD_MS),
    parameter int SIM_PERIOD_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    generate_clock_enable_if.master        tick
);

`ifdef GEN_CLK_ENABLE_SIM_SHORT_EN
    localparam int P = SIM_PERIOD_CYCLES;
`else
    localparam int P = PERIOD_CYCLES;
`endif

    localparam int CW = count_width(P);

    if (P < 1) begin : g_bad_period
        $error("generate_clock_enable: period must be at least 1 cycle (got %0d)", P);
    end

    logic [CW-1:0] count;
    logic          terminal;

    mod_counter #(
        .MODULUS (P)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .terminal (terminal)
    );

    assign tick.six_hundred_sixty_ms = terminal;
    assign tick.phase                = 32'(count);

endmodule

// File: tb/tb_generate_clock_enable.sv
// Directed bench for generate_clock_enable: periods 4, 1, 16 and the default build.
module tb_generate_clock_enable;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    generate_clock_enable_if if4 ();
    generate_clock_enable_if if1 ();
    generate_clock_enable_if if16 ();
    generate_clock_enable_if ifd ();

    generate_clock_enable #(.PERIOD_CYCLES(4), .SIM_PERIOD_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .tick(if4));
    generate_clock_enable #(.PERIOD_CYCLES(1), .SIM_PERIOD_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .tick(if1));
    generate_clock_enable #(.PERIOD_CYCLES(16), .SIM_PERIOD_CYCLES(16)) dut16 (
        .clk(clk), .reset(reset), .tick(if16));
    generate_clock_enable dutd (
        .clk(clk), .reset(reset), .tick(ifd));

`ifdef GEN_CLK_ENABLE_SIM_SHORT_EN
    localparam int PD = 4;
`else
    localparam int PD = 33_000_000;
`endif

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks all DUTs for cycles 1..ncyc after a reset release; cycle n follows n-1 rising edges.
    task automatic run_cycles(input string tag, input int ncyc);
        for (int n = 1; n <= ncyc; n++) begin
            #1;
            check({tag, "_p4"},   int'(if4.six_hundred_sixty_ms),  int'(n % 4 == 0));
            check({tag, "_p1"},   int'(if1.six_hundred_sixty_ms),  1);
            check({tag, "_p16"},  int'(if16.six_hundred_sixty_ms), int'(n % 16 == 0));
            check({tag, "_cnt16"}, int'(if16.phase),               (n - 1) % 16);
            check({tag, "_pdef"}, int'(ifd.six_hundred_sixty_ms),  int'(n % PD == 0));
            @(negedge clk);
        end
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_p4"},    int'(if4.six_hundred_sixty_ms),  0);
        check({tag, "_p1"},    int'(if1.six_hundred_sixty_ms),  0);
        check({tag, "_p16"},   int'(if16.six_hundred_sixty_ms), 0);
        check({tag, "_cnt16"}, int'(if16.phase),                0);
        check({tag, "_pdef"},  int'(ifd.six_hundred_sixty_ms),  0);
    endtask

    initial begin
        // Reset state, immediately and held for two cycles.
        #1;
        check_in_reset("reset_t0");
        check("default_period", dutd.P, PD);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_in_reset("reset_hold");
        end

        // Release and run past three 16-cycle wraps.
        @(negedge clk);
        reset = 1'b1;
        run_cycles("run", 53);

        // Now at the start of cycle 54: two cycles after the strobe of cycle 52.
        #1;
        check("pre_mid_cnt16", int'(if16.phase), 53 % 16);
        reset = 1'b0;
        #1;
        check_in_reset("mid_reset_now");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_in_reset("mid_reset_hold");
        end
        @(negedge clk);
        reset = 1'b1;
        run_cycles("after_mid", 7);

        // Start of cycle 8: the P=4 strobe is high, reset must drop it at once.
        #1;
        check("pre_strobe_reset_p4", int'(if4.six_hundred_sixty_ms), 1);
        reset = 1'b0;
        #1;
        check_in_reset("strobe_reset_now");
        @(negedge clk);
        #1;
        check_in_reset("strobe_reset_hold");
        @(negedge clk);
        reset = 1'b1;
        run_cycles("after_strobe", 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
